// File: rtl/ground_touch_tracker_pkg.sv
// ground_pkg: shared state encoding, screen bounds, block count and the
// landing-qualification helper for the ground-touch tracker.
`default_nettype none

package ground_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_TOUCHED = 2'd2
  } bk_state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int NUM_BK   = 3;

  // 11 bits hold every sum here (max 639+64, 479+32) without wrapping.
  function automatic logic land_qual(
    input logic [10:0] px,
    input logic [10:0] pb,
    input logic [10:0] bx,
    input logic [10:0] by,
    input logic [10:0] pw,
    input logic [10:0] bw,
    input logic [10:0] tol
  );
    logic hov, vq;
    hov = ((px + pw) > bx) && (px < (bx + bw));
    vq  = (pb >= by) && (pb <= (by + tol));
    return hov && vq;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ground_touch_tracker_if.sv
// Bundle of the tracker's per-frame inputs and per-block touch outputs.
`default_nettype none

interface ground_touch_tracker_if;
  logic [31:0] ipcnt;
  logic [9:0]  player_x;
  logic [8:0]  player_y;
  logic        level_clear;
  logic [2:0]  bk_touched;
  logic [2:0]  touch_pulse;
  logic        on_ground;

  modport master (
    output ipcnt, player_x, player_y, level_clear,
    input  bk_touched, touch_pulse, on_ground
  );

  modport slave (
    input  ipcnt, player_x, player_y, level_clear,
    output bk_touched, touch_pulse, on_ground
  );
endinterface

`default_nettype wire

// File: rtl/ground_touch_tracker_fsm.sv
// ground_touch_fsm: one block's debounce FSM, tick counter and rise pulse.
`default_nettype none

module ground_touch_fsm
  import ground_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic q_i,
  input  logic level_clear,
  output logic touched,
  output logic pulse
);

  bk_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pulse_q, pulse_d;
  logic [2:0] cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    cnt_inc = cnt_q + 3'd1;
    if (level_clear) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (q_i) begin
            cnt_d = 3'd1;
            if (DEBOUNCE == 1) begin
              state_d = ST_TOUCHED;
              pulse_d = 1'b1;
            end else begin
              state_d = ST_ARM;
            end
          end
        end
        ST_ARM: begin
          if (q_i) begin
            cnt_d = cnt_inc;
            if (cnt_inc == 3'(DEBOUNCE)) begin
              state_d = ST_TOUCHED;
              pulse_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end
        end
        ST_TOUCHED: state_d = ST_TOUCHED;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  assign touched = (state_q == ST_TOUCHED);
  assign pulse   = pulse_q;

endmodule

`default_nettype wire

// File: rtl/ground_touch_tracker.sv
// ground_touch_tracker: tick decode, player/block geometry and three
// per-block touch FSMs feeding the ground-tile renderer.
`default_nettype none

module ground_touch_tracker
  import ground_pkg::*;
#(
  parameter int TICK_VAL = 6000000,
  parameter int PW       = 32,
  parameter int PH       = 32,
  parameter int BK0_X    = 100,
  parameter int BK0_Y    = 400,
  parameter int BK1_X    = 260,
  parameter int BK1_Y    = 360,
  parameter int BK2_X    = 420,
  parameter int BK2_Y    = 400,
  parameter int BK_W     = 64,
  parameter int LAND_TOL = 4,
  parameter int DEBOUNCE = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  ground_touch_tracker_if.slave bus
);

  localparam logic [10:0] BX [NUM_BK] = '{11'(BK0_X), 11'(BK1_X), 11'(BK2_X)};
  localparam logic [10:0] BY [NUM_BK] = '{11'(BK0_Y), 11'(BK1_Y), 11'(BK2_Y)};

  logic              tick;
  logic [10:0]       px, pb;
  logic [NUM_BK-1:0] q, touched, pulse;
  logic              on_ground_q, on_ground_d;

  assign tick = (bus.ipcnt == 32'(TICK_VAL));
  assign px   = {1'b0, bus.player_x};
  assign pb   = {2'b00, bus.player_y} + 11'(PH);

  for (genvar i = 0; i < NUM_BK; i++) begin : g_bk
    assign q[i] = land_qual(px, pb, BX[i], BY[i], 11'(PW), 11'(BK_W), 11'(LAND_TOL));

    ground_touch_fsm #(.DEBOUNCE(DEBOUNCE)) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .q_i         (q[i]),
      .level_clear (bus.level_clear),
      .touched     (touched[i]),
      .pulse       (pulse[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) on_ground_q <= 1'b0;
    else        on_ground_q <= on_ground_d;
  end

  always_comb begin
    on_ground_d = on_ground_q;
    if (bus.level_clear) on_ground_d = 1'b0;
    else if (tick)       on_ground_d = |q;
  end

  assign bus.bk_touched  = touched;
  assign bus.touch_pulse = pulse;
  assign bus.on_ground   = on_ground_q;

endmodule

`default_nettype wire

// File: tb/tb_ground_touch_tracker.sv
// Directed bench for ground_touch_tracker: default instance plus one with
// block 1 moved next to block 0 so a straddle qualifies on both.
`default_nettype none

module tb_ground_touch_tracker;

  localparam int TICK_VAL = 6000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ground_touch_tracker_if bus1 ();
  ground_touch_tracker_if bus2 ();

  ground_touch_tracker dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  ground_touch_tracker #(.BK1_X(180), .BK1_Y(400)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic set_pos(input int x, input int y);
    bus1.player_x = 10'(x); bus1.player_y = 9'(y);
    bus2.player_x = 10'(x); bus2.player_y = 9'(y);
  endtask

  // One tick cycle; returns at the negedge after the sampling edge.
  task automatic do_tick();
    @(negedge clk);
    bus1.ipcnt = 32'(TICK_VAL); bus2.ipcnt = 32'(TICK_VAL);
    @(negedge clk);
    bus1.ipcnt = 32'd0; bus2.ipcnt = 32'd0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus1.level_clear = 1'b1; bus2.level_clear = 1'b1;
    @(negedge clk);
    bus1.level_clear = 1'b0; bus2.level_clear = 1'b0;
  endtask

  task automatic chk3(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    chk3("reset_bk", bus1.bk_touched, 3'b000);
    chk3("reset_pulse", bus1.touch_pulse, 3'b000);
    chk1("reset_on_ground", bus1.on_ground, 1'b0);
  endtask

  task automatic test_landing();
    do_clear();
    set_pos(110, 368);
    do_tick();
    chk3("land_t1_bk", bus1.bk_touched, 3'b000);
    chk1("land_t1_on_ground", bus1.on_ground, 1'b1);
    repeat (3) @(negedge clk);
    do_tick();
    chk3("land_t2_bk", bus1.bk_touched, 3'b001);
    chk3("land_t2_pulse", bus1.touch_pulse, 3'b001);
    chk1("land_t2_on_ground", bus1.on_ground, 1'b1);
    @(negedge clk);
    chk3("land_pulse_drop", bus1.touch_pulse, 3'b000);
    chk3("land_bk_hold", bus1.bk_touched, 3'b001);
  endtask

  task automatic test_abort();
    do_clear();
    set_pos(110, 368);
    do_tick();
    set_pos(110, 300);
    do_tick();
    chk3("abort_bk", bus1.bk_touched, 3'b000);
    chk1("abort_on_ground", bus1.on_ground, 1'b0);
    set_pos(110, 368);
    do_tick();
    chk3("relaunch_t1_bk", bus1.bk_touched, 3'b000);
    do_tick();
    chk3("relaunch_t2_bk", bus1.bk_touched, 3'b001);
  endtask

  task automatic test_straddle();
    do_clear();
    set_pos(150, 368);
    do_tick();
    do_tick();
    chk3("straddle_def_bk", bus1.bk_touched, 3'b001);
    chk3("straddle_adj_bk", bus2.bk_touched, 3'b011);
    chk3("straddle_adj_pulse", bus2.touch_pulse, 3'b011);
  endtask

  task automatic test_boundary();
    do_clear();
    set_pos(110, 372);           // pb = 404
    do_tick(); do_tick();
    chk3("pb404_bk", bus1.bk_touched, 3'b001);
    do_clear();
    set_pos(110, 373);           // pb = 405
    do_tick(); do_tick();
    chk3("pb405_bk", bus1.bk_touched, 3'b000);
    chk1("pb405_on_ground", bus1.on_ground, 1'b0);
    do_clear();
    set_pos(110, 367);           // pb = 399
    do_tick(); do_tick();
    chk3("pb399_bk", bus1.bk_touched, 3'b000);
    do_clear();
    set_pos(68, 368);            // right edge = 100
    do_tick(); do_tick();
    chk3("edge100_bk", bus1.bk_touched, 3'b000);
    chk1("edge100_on_ground", bus1.on_ground, 1'b0);
  endtask

  task automatic test_sticky_clear();
    do_clear();
    set_pos(110, 368);
    do_tick(); do_tick();
    set_pos(110, 300);
    do_tick();
    chk3("sticky_bk", bus1.bk_touched, 3'b001);
    chk1("sticky_on_ground", bus1.on_ground, 1'b0);
    set_pos(110, 368);
    @(negedge clk);
    bus1.ipcnt = 32'(TICK_VAL); bus2.ipcnt = 32'(TICK_VAL);
    bus1.level_clear = 1'b1;     bus2.level_clear = 1'b1;
    @(negedge clk);
    bus1.ipcnt = 32'd0;          bus2.ipcnt = 32'd0;
    bus1.level_clear = 1'b0;     bus2.level_clear = 1'b0;
    chk3("clr_tick_bk", bus1.bk_touched, 3'b000);
    chk3("clr_tick_pulse", bus1.touch_pulse, 3'b000);
    chk1("clr_tick_on_ground", bus1.on_ground, 1'b0);
  endtask

  task automatic test_async_reset();
    do_clear();
    set_pos(110, 368);
    do_tick();
    chk1("arm_on_ground", bus1.on_ground, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_arm_on_ground", bus1.on_ground, 1'b0);
    chk3("rst_arm_bk", bus1.bk_touched, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    do_tick();
    chk3("post_rst_t1_bk", bus1.bk_touched, 3'b000);
    do_tick();
    chk3("post_rst_t2_bk", bus1.bk_touched, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    chk3("rst_touched_bk", bus1.bk_touched, 3'b000);
    chk3("rst_touched_pulse", bus1.touch_pulse, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus1.ipcnt = 32'd0; bus2.ipcnt = 32'd0;
    bus1.level_clear = 1'b0; bus2.level_clear = 1'b0;
    set_pos(0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_landing();
    test_abort();
    test_straddle();
    test_boundary();
    test_sticky_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ground_touch_tracker.md
# ground_touch_tracker

Upstream stage of the ground-tile renderer. It watches the player's bounding box against three fixed ground blocks and produces the sticky per-block `bk_touched` flags. The renderer consumes those flags, one bit per ground instance, to start its crumble animation. Landing is evaluated once per animation tick, the same `ipcnt` event the renderer uses, and must persist for a debounce window before a block latches as touched.

## Interface
Parameters:
- `TICK_VAL`, 6000000: `ipcnt` value that marks an evaluation tick.
- `PW`, 32: player width in pixels.
- `PH`, 32: player height in pixels.
- `BK0_X`/`BK0_Y`, 100/400: block 0 top-left corner.
- `BK1_X`/`BK1_Y`, 260/360: block 1 top-left corner.
- `BK2_X`/`BK2_Y`, 420/400: block 2 top-left corner.
- `BK_W`, 64: block width, common to all blocks.
- `LAND_TOL`, 4: allowed gap in pixels between player bottom and block top.
- `DEBOUNCE`, 2: consecutive qualifying ticks needed to latch a block (1..7).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ipcnt` in 32: free-running frame counter, shared with the renderer.
- `player_x` in 10: player left edge, 0..639.
- `player_y` in 9: player top edge, 0..479.
- `level_clear` in 1: synchronous one-cycle pulse that clears all touched state.
- `bk_touched` out 3: sticky touched flag per block; bit i drives renderer i.
- `touch_pulse` out 3: one-cycle pulse on the cycle a bit of `bk_touched` rises.
- `on_ground` out 1: some block geometrically qualified at the most recent tick.

## Operation
- `tick` = (`ipcnt` == `TICK_VAL`). All evaluation happens only on tick cycles.
- Geometry is computed in 11-bit unsigned arithmetic. Nothing may wrap.
  - `pb` = `player_y` + `PH`.
  - `hov_i` = (`player_x` + `PW` > `BKi_X`) && (`player_x` < `BKi_X` + `BK_W`).
  - `vq_i` = (`pb` >= `BKi_Y`) && (`pb` <= `BKi_Y` + `LAND_TOL`).
  - `q_i` = `hov_i` && `vq_i`.
- Each block runs an independent three-state FSM with a 3-bit counter `cnt`:
  - IDLE: on tick with `q_i` set, go to ARM with `cnt` = 1. If `DEBOUNCE` = 1, go directly to TOUCHED instead.
  - ARM: on tick with `q_i` set, increment `cnt`. When the incremented value reaches `DEBOUNCE`, go to TOUCHED. On tick with `q_i` clear, return to IDLE with `cnt` = 0. Non-tick cycles hold state.
  - TOUCHED: terminal. Ignores `q_i`. Leaves only on `level_clear` or reset.
- `level_clear` forces every FSM to IDLE with `cnt` = 0 and zeroes all outputs on the next edge. It has priority over a simultaneous tick.
- `bk_touched[i]` = (state_i == TOUCHED), registered.
- `touch_pulse[i]` is high for exactly one cycle per IDLE/ARM→TOUCHED transition. It is never asserted on a clear or reset edge.
- `on_ground` is updated only on tick cycles: it takes |`q`. It holds between ticks.
- Several blocks may qualify on the same tick (for example, the player straddling two blocks). Each FSM advances independently, and multiple `touch_pulse` bits may rise together.

## Timing
- Reset values: all FSMs IDLE; `cnt` = 0; `bk_touched` = 0; `touch_pulse` = 0; `on_ground` = 0.
- Latency: the edge that samples the qualifying tick also registers `bk_touched` and `touch_pulse`. Both are visible the cycle after the tick cycle.
- Time from the first qualifying tick to `bk_touched`: (`DEBOUNCE` − 1) ticks plus 1 cycle.
- Inputs are sampled only on tick cycles. Position changes between ticks have no effect.
- `rst_n` asserted mid-ARM or mid-TOUCHED: all state returns immediately and asynchronously to reset values.
- `rst_n` deassertion is expected to be synchronised externally.

## Structure
- Shared package `ground_pkg` holds:
  - the FSM state encoding (IDLE = 2'd0, ARM = 2'd1, TOUCHED = 2'd2);
  - the screen bounds 640×480;
  - `NUM_BK` = 3.
- Sub-module `ground_touch_fsm`: one block's FSM, counter and pulse logic. Its inputs are `tick`, `q_i` and `level_clear`. The top instantiates it three times.
- Geometry comparators and the tick decode live in the top.

## Test plan
- Default parameters; `player_x`=110, `player_y`=368 (`pb`=400) across two ticks:
  - After the second tick, `bk_touched` = 3'b001.
  - `touch_pulse[0]` is high for exactly one cycle.
  - `on_ground` = 1.
- Qualify at tick 1, then move to `player_y`=300 before tick 2:
  - Block 0 returns to IDLE; `bk_touched` stays 0.
  - A later two-tick landing latches normally.
- Straddle: `player_x`=150, `player_y`=368 for two ticks:
  - Overlaps block 0 only (`hov_1` fails, 182 < 260), so the result is 3'b001.
  - Repeat with the block 1 geometry adjusted so both blocks qualify: both bits and both pulses rise on the same cycle.
- Boundaries: `pb` = 404 qualifies; `pb` = 405 does not; `player_x` + `PW` = 100 exactly does not qualify.
- After latching: player leaves, `bk_touched` stays 1. `level_clear` coincident with a qualifying tick yields 0, with no pulse.
- `rst_n` pulsed low while block 0 is in ARM:
  - Outputs go to 0 immediately.
  - After release, one qualifying tick alone does not latch.
